controllo_quadrato: RTL and testbench

//  Frame-synchronous motion controller for the on-screen square/frame shapes.
//  - Each frame tick advances the shape centre (X_POS, Y_POS) by PASSO pixels per axis and bounces it off the screen edges.
//  - X_POS/Y_POS feed the rectangle/frame hit-test blocks directly.
//  - CORNICE_ON gates frame (cornice) visibility for blinking.
//  - Positions update only inside the tick-triggered sequence, so the pixel path never sees a half-updated coordinate pair.

---
 rtl/controllo_quadrato_pkg.sv | 21 ++
 rtl/asse_rimbalzo.sv | 51 +++++
 rtl/controllo_quadrato.sv | 118 +++++++++++
 tb/tb_controllo_quadrato.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controllo_quadrato_pkg.sv
// rtl/controllo_quadrato_pkg.sv - shared widths, screen defaults and FSM encoding for the square motion controller
package controllo_quadrato_pkg;

  localparam int COORD_W   = 11;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef logic [1:0] stato_t;

  localparam stato_t ATTESA = 2'd0;
  localparam stato_t CALC_X = 2'd1;
  localparam stato_t CALC_Y = 2'd2;
  localparam stato_t COMMIT = 2'd3;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               dir;
    logic               bounce;
  } asse_t;

endpackage

// File: rtl/asse_rimbalzo.sv
// rtl/asse_rimbalzo.sv - combinational next position, direction and bounce flag for one screen axis
module asse_rimbalzo
  import controllo_quadrato_pkg::*;
#(
  parameter int LIMITE = H_RES_DEF,
  parameter int MEZZA  = 50,
  parameter int PASSO  = 2
) (
  input  logic [COORD_W-1:0] pos,
  input  logic               dir,
  output asse_t              next
);

  localparam int W = COORD_W + 1;
  localparam logic [W-1:0]       LIM_ALTO  = W'(LIMITE - 1 - MEZZA);
  localparam logic [W-1:0]       LIM_BASSO = W'(MEZZA);
  localparam logic [W-1:0]       SOGLIA    = W'(MEZZA + PASSO);
  localparam logic [W-1:0]       PASSO_W   = W'(PASSO);
  localparam logic [COORD_W-1:0] PASSO_N   = COORD_W'(PASSO);

  logic [W-1:0] pos_w;
  logic [W-1:0] somma;

  // One extra bit keeps pos+PASSO from wrapping before the edge compare.
  assign pos_w = {1'b0, pos};
  assign somma = pos_w + PASSO_W;

  always_comb begin
    next.pos    = pos;
    next.dir    = dir;
    next.bounce = 1'b0;
    if (dir) begin
      if (somma > LIM_ALTO) begin
        next.pos    = LIM_ALTO[COORD_W-1:0];
        next.dir    = 1'b0;
        next.bounce = 1'b1;
      end else begin
        next.pos = somma[COORD_W-1:0];
      end
    end else begin
      if (pos_w < SOGLIA) begin
        next.pos    = LIM_BASSO[COORD_W-1:0];
        next.dir    = 1'b1;
        next.bounce = 1'b1;
      end else begin
        next.pos = pos - PASSO_N;
      end
    end
  end

endmodule

// File: rtl/controllo_quadrato.sv
// rtl/controllo_quadrato.sv - frame-synchronous bouncing motion controller for the on-screen square/frame
module controllo_quadrato
  import controllo_quadrato_pkg::*;
#(
  parameter int H_RES        = H_RES_DEF,
  parameter int V_RES        = V_RES_DEF,
  parameter int LARGHEZZA    = 100,
  parameter int ALTEZZA      = 100,
  parameter int PASSO        = 2,
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FRAME_TICK,
  input  logic               ENABLE,
  input  logic               STEP,
  output logic [COORD_W-1:0] X_POS,
  output logic [COORD_W-1:0] Y_POS,
  output logic               DIR_X,
  output logic               DIR_Y,
  output logic               RIMBALZO,
  output logic               OVERRUN,
  output logic               CORNICE_ON,
  output logic               BUSY
);

  localparam int LARG2   = LARGHEZZA / 2;
  localparam int ALT2    = ALTEZZA / 2;
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  stato_t             state;
  logic               armed;
  logic               go;
  asse_t              x_sh, y_sh;
  asse_t              x_next, y_next;
  logic [BLINK_W-1:0] blink_cnt;

  asse_rimbalzo #(.LIMITE(H_RES), .MEZZA(LARG2), .PASSO(PASSO)) u_asse_x (
    .pos  (X_POS),
    .dir  (DIR_X),
    .next (x_next)
  );

  asse_rimbalzo #(.LIMITE(V_RES), .MEZZA(ALT2), .PASSO(PASSO)) u_asse_y (
    .pos  (Y_POS),
    .dir  (DIR_Y),
    .next (y_next)
  );

  // A STEP coinciding with the tick counts as already armed.
  assign go   = FRAME_TICK && (ENABLE || armed || STEP);
  assign BUSY = (state != ATTESA);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ATTESA;
      armed      <= 1'b0;
      x_sh       <= '0;
      y_sh       <= '0;
      X_POS      <= COORD_W'(X_INIT);
      Y_POS      <= COORD_W'(Y_INIT);
      DIR_X      <= 1'b1;
      DIR_Y      <= 1'b1;
      RIMBALZO   <= 1'b0;
      OVERRUN    <= 1'b0;
      CORNICE_ON <= 1'b1;
      blink_cnt  <= '0;
    end else begin
      RIMBALZO <= 1'b0;
      OVERRUN  <= FRAME_TICK && (state != ATTESA);

      if (state == ATTESA && go) begin
        armed <= 1'b0;
      end else if (STEP && !ENABLE) begin
        armed <= 1'b1;
      end

      case (state)
        ATTESA: if (go) state <= CALC_X;
        CALC_X: begin
          x_sh  <= x_next;
          state <= CALC_Y;
        end
        CALC_Y: begin
          y_sh  <= y_next;
          state <= COMMIT;
        end
        COMMIT: begin
          // Both axes land on the same edge so the pixel path never sees a mixed pair.
          X_POS    <= x_sh.pos;
          DIR_X    <= x_sh.dir;
          Y_POS    <= y_sh.pos;
          DIR_Y    <= y_sh.dir;
          RIMBALZO <= x_sh.bounce | y_sh.bounce;
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt  <= '0;
            CORNICE_ON <= ~CORNICE_ON;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
          state <= ATTESA;
        end
        default: state <= ATTESA;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      init_in_range: assert (X_INIT >= LARG2 && X_INIT <= H_RES - 1 - LARG2 &&
                             Y_INIT >= ALT2  && Y_INIT <= V_RES - 1 - ALT2);
    end
  end

endmodule

// File: tb/tb_controllo_quadrato.sv
// tb/tb_controllo_quadrato.sv - randomized self-checking bench for controllo_quadrato against a motion model
module tb_controllo_quadrato;

  localparam int H     = 640;
  localparam int V     = 481;
  localparam int HALF  = 50;
  localparam int PASSO = 2;
  localparam int BL    = 2;
  localparam int XI    = 320;
  localparam int YI    = 240;

  logic        clk = 1'b0;
  logic        rst, frame_tick, enable, step;
  logic [10:0] x_pos, y_pos;
  logic        dir_x, dir_y, rimbalzo, overrun, cornice_on, busy;

  int errs   = 0;
  int checks = 0;

  int m_x, m_y, m_cnt;
  bit m_dx, m_dy, m_b, m_corn;

  always #5 clk = ~clk;

  controllo_quadrato #(.V_RES(V), .BLINK_FRAMES(BL)) dut (
    .CLK        (clk),
    .RST        (rst),
    .FRAME_TICK (frame_tick),
    .ENABLE     (enable),
    .STEP       (step),
    .X_POS      (x_pos),
    .Y_POS      (y_pos),
    .DIR_X      (dir_x),
    .DIR_Y      (dir_y),
    .RIMBALZO   (rimbalzo),
    .OVERRUN    (overrun),
    .CORNICE_ON (cornice_on),
    .BUSY       (busy)
  );

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  // Move one axis by PASSO; if that would push the shape past the edge, park it on the edge and turn round.
  task automatic axis_model(input int p, input bit d, input int res,
                            output int np, output bit nd, output bit b);
    nd = d;
    b  = 1'b0;
    if (d) begin
      if (p + PASSO > res - 1 - HALF) begin
        np = res - 1 - HALF; nd = 1'b0; b = 1'b1;
      end else np = p + PASSO;
    end else begin
      if (p - PASSO < HALF) begin
        np = HALF; nd = 1'b1; b = 1'b1;
      end else np = p - PASSO;
    end
  endtask

  task automatic model_reset;
    m_x = XI; m_y = YI; m_dx = 1'b1; m_dy = 1'b1;
    m_b = 1'b0; m_cnt = 0; m_corn = 1'b1;
  endtask

  task automatic model_step;
    int nx, ny;
    bit ndx, ndy, bx, by;
    axis_model(m_x, m_dx, H, nx, ndx, bx);
    axis_model(m_y, m_dy, V, ny, ndy, by);
    m_x = nx; m_dx = ndx; m_y = ny; m_dy = ndy;
    m_b = bx | by;
    m_cnt++;
    if (m_cnt == BL) begin
      m_cnt  = 0;
      m_corn = ~m_corn;
    end
  endtask

  function automatic logic [26:0] exp_vec(input bit bsy);
    return {11'(m_x), 11'(m_y), m_dx, m_dy, m_b, m_corn, bsy};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {x_pos, y_pos, dir_x, dir_y, rimbalzo, cornice_on, busy};
  endfunction

  task automatic do_update(input bit tail);
    frame_tick = 1'b1;
    step_clk();
    frame_tick = 1'b0;
    step = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL busy_after_tick got=%b exp=1", busy);
    end
    step_clk();
    step_clk();
    checks++;
    if ({x_pos, y_pos} !== {11'(m_x), 11'(m_y)}) begin
      errs++; $display("FAIL hold_before_commit got=%0d,%0d exp=%0d,%0d", x_pos, y_pos, m_x, m_y);
    end
    step_clk();
    model_step();
    checks++;
    if (dut_vec() !== exp_vec(1'b0)) begin
      errs++; $display("FAIL update got=%h exp=%h (x,y,dx,dy,rimb,corn,busy)", dut_vec(), exp_vec(1'b0));
    end
    if (tail) begin
      step_clk();
      checks++;
      if (rimbalzo !== 1'b0 || overrun !== 1'b0) begin
        errs++; $display("FAIL pulse_width got rimb=%b ovr=%b exp=0,0", rimbalzo, overrun);
      end
    end
  endtask

  task automatic random_gap;
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      step = 1'($urandom_range(0, 1));
      step_clk();
    end
    step = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; frame_tick = 1'b0; enable = 1'b0; step = 1'b0;
    step_clk();
    step_clk();
    rst = 1'b0;
    model_reset();
    checks++;
    if (dut_vec() !== exp_vec(1'b0) || overrun !== 1'b0) begin
      errs++; $display("FAIL reset got=%h ovr=%b exp=%h ovr=0", dut_vec(), overrun, exp_vec(1'b0));
    end
  endtask

  task automatic test_first_update;
    enable = 1'b1;
    do_update(1'b1);
    checks++;
    if (x_pos !== 11'd322 || y_pos !== 11'd242 || dir_x !== 1'b1 || dir_y !== 1'b1) begin
      errs++; $display("FAIL first_update got=%0d,%0d exp=322,242", x_pos, y_pos);
    end
  endtask

  task automatic test_x_bounce;
    int n = 0;
    while (!(m_x == 588 && m_dx) && n < 300) begin
      random_gap();
      do_update(1'b1);
      n++;
    end
    checks++;
    if (!(m_x == 588 && m_dx) || x_pos !== 11'd588) begin
      errs++; $display("FAIL x_bounce_setup got=%0d exp=588", x_pos);
    end
    do_update(1'b0);
    checks++;
    if (x_pos !== 11'd589 || dir_x !== 1'b0 || rimbalzo !== 1'b1) begin
      errs++; $display("FAIL x_bounce got x=%0d dx=%b rimb=%b exp 589,0,1", x_pos, dir_x, rimbalzo);
    end
    step_clk();
    do_update(1'b1);
    checks++;
    if (x_pos !== 11'd587 || dir_x !== 1'b0) begin
      errs++; $display("FAIL x_after_bounce got x=%0d dx=%b exp 587,0", x_pos, dir_x);
    end
  endtask

  task automatic test_y_bounce;
    int n = 0;
    while (!(m_y == 52 && !m_dy) && n < 400) begin
      random_gap();
      do_update(1'b1);
      n++;
    end
    checks++;
    if (!(m_y == 52 && !m_dy) || y_pos !== 11'd52) begin
      errs++; $display("FAIL y_bounce_setup got=%0d exp=52", y_pos);
    end
    do_update(1'b0);
    checks++;
    if (y_pos !== 11'd50 || dir_y !== 1'b0) begin
      errs++; $display("FAIL y_exact_limit got y=%0d dy=%b exp 50,0", y_pos, dir_y);
    end
    step_clk();
    do_update(1'b0);
    checks++;
    if (y_pos !== 11'd50 || dir_y !== 1'b1 || rimbalzo !== 1'b1) begin
      errs++; $display("FAIL y_bounce got y=%0d dy=%b rimb=%b exp 50,1,1", y_pos, dir_y, rimbalzo);
    end
    step_clk();
  endtask

  task automatic paused_tick(input string name);
    frame_tick = 1'b1;
    step_clk();
    frame_tick = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL %s_busy got=%b exp=0", name, busy);
    end
    repeat (4) step_clk();
    checks++;
    if (dut_vec() !== {11'(m_x), 11'(m_y), m_dx, m_dy, 1'b0, m_corn, 1'b0}) begin
      errs++; $display("FAIL %s_hold got=%0d,%0d exp=%0d,%0d", name, x_pos, y_pos, m_x, m_y);
    end
  endtask

  task automatic test_pause;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) paused_tick("pause");
    step = 1'b1;
    step_clk();
    step = 1'b0;
    repeat (2) step_clk();
    do_update(1'b1);
    paused_tick("after_step");
    step = 1'b1;
    do_update(1'b1);
    paused_tick("after_same_cycle_step");
  endtask

  task automatic test_overrun;
    enable = 1'b1;
    frame_tick = 1'b1;
    step_clk();
    step_clk();
    frame_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL overrun_pulse got ovr=%b busy=%b exp 1,1", overrun, busy);
    end
    step_clk();
    checks++;
    if (overrun !== 1'b0) begin
      errs++; $display("FAIL overrun_width got=%b exp=0", overrun);
    end
    step_clk();
    model_step();
    checks++;
    if (dut_vec() !== exp_vec(1'b0)) begin
      errs++; $display("FAIL overrun_update got=%h exp=%h", dut_vec(), exp_vec(1'b0));
    end
    repeat (5) step_clk();
    checks++;
    if ({x_pos, y_pos, busy} !== {11'(m_x), 11'(m_y), 1'b0}) begin
      errs++; $display("FAIL overrun_single got=%0d,%0d exp=%0d,%0d", x_pos, y_pos, m_x, m_y);
    end
  endtask

  task automatic test_reset_mid;
    frame_tick = 1'b1;
    step_clk();
    frame_tick = 1'b0;
    step_clk();
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    model_reset();
    checks++;
    if (dut_vec() !== exp_vec(1'b0)) begin
      errs++; $display("FAIL reset_mid got=%h exp=%h", dut_vec(), exp_vec(1'b0));
    end
    repeat (4) step_clk();
    checks++;
    if (x_pos !== 11'd320 || y_pos !== 11'd240 || busy !== 1'b0) begin
      errs++; $display("FAIL reset_mid_no_commit got=%0d,%0d exp=320,240", x_pos, y_pos);
    end
  endtask

  task automatic test_blink;
    bit exp_c[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_update(1'b1);
      checks++;
      if (cornice_on !== exp_c[i]) begin
        errs++; $display("FAIL blink_%0d got=%b exp=%b", i, cornice_on, exp_c[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) do_update(1'b0);
    step_clk();
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL back_to_back got ovr=%b busy=%b exp 0,0", overrun, busy);
    end
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; enable = 1'b0; step = 1'b0;
    test_reset();
    test_first_update();
    test_x_bounce();
    test_y_bounce();
    test_pause();
    test_overrun();
    test_reset_mid();
    test_blink();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
